// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares the external block bus between I-cache refill,
// D-cache refill/write-back and the DMA controller (BR/BG handshake).
module mem_bus_arbiter #(
  parameter int LATENCY    = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_ready,
  input  logic                  br,
  output logic                  bg,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_sel,
  output logic                  busy
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_I   = 2'd1,
    SERVE_D   = 2'd2,
    GRANT_DMA = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  last_dma, last_dma_nxt;
  logic [ADDR_WIDTH-1:0] addr_lat, addr_nxt;
  logic                  wr_lat, wr_nxt;

  logic cache_first;
  logic acc_dma;
  logic acc_d;
  logic acc_i;

  // After a DMA tenure any pending cache request goes first, so neither side starves.
  always_comb begin
    cache_first = last_dma && (d_req || i_req);
    acc_dma     = br && !cache_first;
    acc_d       = d_req && !acc_dma;
    acc_i       = i_req && !d_req && !acc_dma;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_dma_nxt = last_dma;
    addr_nxt     = addr_lat;
    wr_nxt       = wr_lat;
    case (state)
      IDLE: begin
        if (acc_dma) begin
          state_nxt    = GRANT_DMA;
          last_dma_nxt = 1'b1;
        end else if (acc_d) begin
          state_nxt    = SERVE_D;
          cnt_nxt      = CNT_LOAD;
          addr_nxt     = d_addr;
          wr_nxt       = d_write;
          last_dma_nxt = 1'b0;
        end else if (acc_i) begin
          state_nxt    = SERVE_I;
          cnt_nxt      = CNT_LOAD;
          addr_nxt     = i_addr;
          wr_nxt       = 1'b0;
          last_dma_nxt = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GRANT_DMA: begin
        if (!br) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dma <= 1'b0;
      addr_lat <= '0;
      wr_lat   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_dma <= last_dma_nxt;
      addr_lat <= addr_nxt;
      wr_lat   <= wr_nxt;
    end
  end

  // Outputs depend on state only; during DMA the controller drives the bus itself.
  always_comb begin
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    bg        = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_sel   = 2'd0;
    busy      = (state != IDLE);
    case (state)
      SERVE_I: begin
        mem_sel  = 2'd1;
        mem_addr = addr_lat;
        mem_read = 1'b1;
        i_ready  = (cnt == '0);
      end
      SERVE_D: begin
        mem_sel   = 2'd2;
        mem_addr  = addr_lat;
        mem_read  = !wr_lat;
        mem_write = wr_lat;
        d_ready   = (cnt == '0);
      end
      GRANT_DMA: begin
        mem_sel = 2'd3;
        bg      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level bus ownership model.
module tb_mem_bus_arbiter;

  localparam int LAT = 4;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_write, br;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_ready, d_ready, bg, mem_read, mem_write, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_sel;

  logic          l1_i_req, l1_d_req, l1_d_write, l1_br;
  logic [AW-1:0] l1_i_addr, l1_d_addr;
  logic          l1_i_ready, l1_d_ready, l1_bg, l1_mem_read, l1_mem_write, l1_busy;
  logic [AW-1:0] l1_mem_addr;
  logic [1:0]    l1_mem_sel;

  int checks   = 0;
  int failures = 0;

  // Model: who owns the bus and how many transfer cycles it has been served.
  int            m_owner;
  int            m_served;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic          m_last_dma;
  logic          exp_ir, exp_dr, exp_bg;

  bit rand_en;
  int br_hold;
  int i_ready_cnt;
  int n;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.LATENCY(LAT), .ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_ready(d_ready),
    .br(br), .bg(bg),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_sel(mem_sel), .busy(busy)
  );

  mem_bus_arbiter #(.LATENCY(1), .ADDR_WIDTH(AW)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ready(l1_i_ready),
    .d_req(l1_d_req), .d_write(l1_d_write), .d_addr(l1_d_addr), .d_ready(l1_d_ready),
    .br(l1_br), .bg(l1_bg),
    .mem_read(l1_mem_read), .mem_write(l1_mem_write), .mem_addr(l1_mem_addr),
    .mem_sel(l1_mem_sel), .busy(l1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_served   = 0;
    m_addr     = '0;
    m_wr       = 1'b0;
    m_last_dma = 1'b0;
  endtask

  task automatic take_cache();
    if (d_req) begin
      m_owner = 2;
      m_addr  = d_addr;
      m_wr    = d_write;
    end else begin
      m_owner = 1;
      m_addr  = i_addr;
      m_wr    = 1'b0;
    end
    m_served   = 1;
    m_last_dma = 1'b0;
  endtask

  task automatic model_advance();
    if (!reset_n) begin
      model_reset();
      return;
    end
    case (m_owner)
      0: begin
        if (m_last_dma && (d_req || i_req)) take_cache();
        else if (br) begin
          m_owner    = 3;
          m_last_dma = 1'b1;
        end else if (d_req || i_req) take_cache();
      end
      1, 2: begin
        if (m_served == LAT) m_owner = 0;
        else m_served++;
      end
      default: if (!br) m_owner = 0;
    endcase
  endtask

  task automatic check_outputs();
    logic          e_read, e_write;
    logic [AW-1:0] e_addr;
    e_read  = (m_owner == 1) || (m_owner == 2 && !m_wr);
    e_write = (m_owner == 2) && m_wr;
    exp_bg  = (m_owner == 3);
    exp_ir  = (m_owner == 1) && (m_served == LAT);
    exp_dr  = (m_owner == 2) && (m_served == LAT);
    e_addr  = (m_owner == 1 || m_owner == 2) ? m_addr : '0;
    chk("mem_sel", 32'(mem_sel), 32'(m_owner));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("rd_wr_bg_busy_ir_dr",
        {26'b0, mem_read, mem_write, bg, busy, i_ready, d_ready},
        {26'b0, e_read, e_write, exp_bg, (m_owner != 0), exp_ir, exp_dr});
  endtask

  task automatic drive_random(input bit i_done, input bit d_done);
    if (!i_req && !i_done && $urandom_range(0, 3) == 0) i_req = 1'b1;
    if (i_req) i_addr = 16'($urandom);
    if (!d_req && !d_done && $urandom_range(0, 3) == 0) begin
      d_req   = 1'b1;
      d_write = 1'($urandom);
    end
    if (d_req) d_addr = 16'($urandom);
    if (!br) begin
      if ($urandom_range(0, 4) == 0) begin
        br      = 1'b1;
        br_hold = $urandom_range(1, 10);
      end
    end else if (exp_bg) begin
      if (br_hold == 0) br = 1'b0;
      else br_hold--;
    end
  endtask

  // One clock cycle: model takes the edge, outputs checked mid-cycle, requesters react.
  task automatic tick();
    bit i_done, d_done;
    model_advance();
    @(negedge clk);
    check_outputs();
    if (i_ready) i_ready_cnt++;
    i_done = exp_ir;
    d_done = exp_dr;
    if (exp_ir) i_req = 1'b0;
    if (exp_dr) d_req = 1'b0;
    if (rand_en) drive_random(i_done, d_done);
  endtask

  initial begin
    reset_n = 1'b0;
    {i_req, d_req, d_write, br} = '0;
    i_addr = '0;
    d_addr = '0;
    {l1_i_req, l1_d_req, l1_d_write, l1_br} = '0;
    l1_i_addr = '0;
    l1_d_addr = '0;
    rand_en = 1'b0;
    br_hold = 0;
    i_ready_cnt = 0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    reset_n = 1'b1;
    check_outputs();

    // Lone I refill
    i_req = 1'b1; i_addr = 16'h0040;
    repeat (6) tick();

    // Simultaneous I and D write-back: D first, then I
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_write = 1'b1; d_addr = 16'h0100;
    repeat (12) tick();

    // br arriving mid I transfer waits for the next IDLE
    i_req = 1'b1; i_addr = 16'h0200;
    tick(); tick();
    br = 1'b1;
    repeat (16) tick();
    br = 1'b0;
    repeat (3) tick();

    // DMA re-request right after release while I is pending
    i_ready_cnt = 0;
    br = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      i_req = 1'b1; i_addr = 16'($urandom);
      br = 1'b0;
      tick();
      br = 1'b1;
      repeat (LAT + 3) tick();
    end
    chk("fair_i_served", 32'(i_ready_cnt), 32'd3);
    chk("fair_dma_regranted", 32'(bg), 32'd1);
    br = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in cycle 2 of a D refill, then restart with d_req held
    d_req = 1'b1; d_write = 1'b0; d_addr = 16'h0300;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    tick(); tick();
    reset_n = 1'b1;
    n = 0;
    while (n < 10 && !d_ready) begin
      tick();
      n++;
    end
    chk("rst_restart_latency", 32'(n), 32'(LAT));
    repeat (2) tick();

    // Randomized traffic
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;

    // LATENCY = 1 instance
    @(negedge clk);
    chk("l1_idle_busy", 32'(l1_busy), 32'd0);
    l1_i_req = 1'b1; l1_i_addr = 16'h1234;
    @(negedge clk);
    chk("l1_i_sel", 32'(l1_mem_sel), 32'd1);
    chk("l1_i_addr", 32'(l1_mem_addr), 32'h1234);
    chk("l1_i_strobes", {26'b0, l1_mem_read, l1_mem_write, l1_bg, l1_busy, l1_i_ready, l1_d_ready},
        32'b100110);
    l1_i_req = 1'b0;
    @(negedge clk);
    chk("l1_i_back_idle", {26'b0, l1_mem_read, l1_mem_write, l1_bg, l1_busy, l1_i_ready, l1_d_ready},
        32'b0);
    l1_d_req = 1'b1; l1_d_write = 1'b1; l1_d_addr = 16'hBEEF;
    @(negedge clk);
    chk("l1_d_sel", 32'(l1_mem_sel), 32'd2);
    chk("l1_d_addr", 32'(l1_mem_addr), 32'hBEEF);
    chk("l1_d_strobes", {26'b0, l1_mem_read, l1_mem_write, l1_bg, l1_busy, l1_i_ready, l1_d_ready},
        32'b010101);
    l1_d_req = 1'b0;
    @(negedge clk);
    chk("l1_d_back_idle", {26'b0, l1_mem_read, l1_mem_write, l1_bg, l1_busy, l1_i_ready, l1_d_ready},
        32'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Owns the single external memory bus. Shares it between three masters: I-cache block refill, D-cache block refill/write-back, and the DMA controller (BR/BG handshake).
Sits between the caches/DMA and memory. Produces the i_ready/d_ready pulses consumed by hazard control, and the bg grant the DMA controller waits on.
Cache transfers are never preempted. DMA holds the bus for as long as it asserts br.

Parameters:
LATENCY, 4, memory cycles per block transfer; legal range >= 1
ADDR_WIDTH, 16, address width

Ports:
clk  in  1  clock
reset_n  in  1  reset
i_req  in  1  I-cache miss request; held until i_ready
i_addr  in  ADDR_WIDTH  I-cache block address
i_ready  out  1  one-cycle pulse: I block transfer complete
d_req  in  1  D-cache request; held until d_ready
d_write  in  1  1 = write-back, 0 = refill
d_addr  in  ADDR_WIDTH  D-cache block address
d_ready  out  1  one-cycle pulse: D block transfer complete
br  in  1  DMA bus request
bg  out  1  DMA bus grant
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_WIDTH  latched address of the owning master
mem_sel  out  2  bus owner: 0 none, 1 I, 2 D, 3 DMA
busy  out  1  state != IDLE

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset: state = IDLE, cnt = 0, last_dma = 0, addr latch = 0. All outputs are 0 while reset_n = 0, and in the first cycle after release.
- States: IDLE, SERVE_I, SERVE_D, GRANT_DMA.

IDLE (acceptance cycle, cycle 0). Arbitration is decided this cycle:
- Default priority: br > d_req > i_req.
- If last_dma = 1 and d_req|i_req is pending: cache requests win, with d_req > i_req. last_dma is cleared on any cache acceptance.
- Accept D: state <= SERVE_D, cnt <= LATENCY-1, latch d_addr and d_write.
- Accept I: state <= SERVE_I, cnt <= LATENCY-1, latch i_addr.
- Accept DMA: state <= GRANT_DMA, last_dma <= 1.
- No request: stay in IDLE, all outputs 0.

SERVE_x (cycles 1..LATENCY):
- Outputs: mem_sel = 1 (I) or 2 (D); mem_addr = latched address.
- Strobes: mem_read = 1, except for a D write-back, which drives mem_write = 1 instead.
- cnt decrements each edge.
- x_ready = 1 combinationally when cnt == 0, i.e. in cycle LATENCY. The next edge returns the state to IDLE.
- br arriving mid-transfer is ignored until IDLE. Requester address changes mid-transfer are ignored (the latch is used).

GRANT_DMA:
- Outputs: bg = 1, mem_sel = 3, mem_read = mem_write = 0, mem_addr = 0. The DMA drives the bus itself.
- Stays while br = 1. br = 0 sampled at an edge -> IDLE, so bg falls one cycle after br falls.

Timing rules:
- At least one IDLE cycle between consecutive grants (bus turnaround).
- Minimum request-to-ready latency is LATENCY cycles.
- Requesters deassert req in the cycle after their ready pulse. A req still high in IDLE is treated as a new request.
- i_ready and d_ready are never high in the same cycle. bg is never high while mem_sel is 1 or 2.
- Asynchronous reset mid-transfer or mid-grant: everything returns to IDLE immediately. The transfer is abandoned, no ready pulse is issued, and a held req restarts from scratch.

Widths: cnt is clog2(LATENCY)+1 bits wide and never underflows (it is reloaded only in IDLE).

Test Plan:
- LATENCY=4, i_req=1, i_addr=0x0040 in cycle 0 -> mem_sel=1, mem_read=1, mem_addr=0x0040 in cycles 1-4; i_ready pulses in cycle 4 only; busy=0 in cycle 5.
- Cycle 0: i_req=1 (0x0010) and d_req=1, d_write=1 (0x0100) together -> D first: mem_write=1, mem_addr=0x0100 in cycles 1-4, d_ready in cycle 4. Then IDLE in cycle 5, I accepted; I served cycles 6-9, i_ready in cycle 9.
- br rises in cycle 2 of an I transfer -> bg stays 0 through cycle 4 and I completes. IDLE cycle 5 grants DMA; bg=1 from cycle 6. Hold br for 12 cycles; br falls in cycle 17 -> bg=0 in cycle 18.
- After a DMA release, br re-asserts immediately while i_req is pending -> I is served first (last_dma rule), and the DMA is granted in the next IDLE. Repeat 3 times -> no starvation of either side.
- Drop reset_n in cycle 2 of a D refill -> all outputs 0 asynchronously, no d_ready. After release with d_req held -> new acceptance; d_ready exactly LATENCY cycles after the acceptance cycle.
- LATENCY=1: i_req in cycle 0 -> mem_read and i_ready both high in cycle 1, IDLE in cycle 2.
